// File: rtl/lottery_pkg.sv
// Shared types, error codes and prize arithmetic for the multi-ticket bet checker.
package lottery_pkg;

  typedef enum logic [1:0] {
    LOAD_WIN = 2'd0,
    IDLE     = 2'd1,
    BET      = 2'd2,
    SCORE    = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_DUP  = 2'b01;
  localparam logic [1:0] ERR_ZERO = 2'b10;
  localparam logic [1:0] ERR_RD   = 2'b11;

  // Prize for one ticket: square of the hit count once the hit count is high enough.
  function automatic int prize(input int hit, input int min_hit);
    return (hit >= min_hit) ? hit * hit : 0;
  endfunction

  // Add a prize to the running total, clamping at the largest value sum_w bits can hold.
  function automatic int sat_add(input int sum, input int prz, input int sum_w);
    longint total;
    longint max_val;
    total   = longint'(sum) + longint'(prz);
    max_val = (longint'(1) << sum_w) - 1;
    return (total > max_val) ? int'(max_val) : int'(total);
  endfunction

endpackage

// File: rtl/check_bet_multi_bet_match.sv
// Combinational lookup of one number against the occupied slots of the winning set.
module bet_match #(
  parameter int NUM_W = 5,
  parameter int BALLS = 4
) (
  input  logic [NUM_W-1:0]            num,
  input  logic [BALLS-1:0][NUM_W-1:0] win,
  input  logic [BALLS-1:0]            valid,
  output logic                        match
);

  // OR together the equality of every occupied slot.
  always_comb begin
    // NOTE: assigning the default first keeps every path driven, so no latch is inferred.
    match = 1'b0;
    for (int i = 0; i < BALLS; i++) begin
      if (valid[i] && (win[i] == num)) match = 1'b1;
    end
  end

endmodule

// File: rtl/check_bet_multi.sv
// Multi-ticket bet checker: loads a winning draw, scores a stream of tickets,
// and keeps a saturating prize total across tickets and draws.
module check_bet_multi
  import lottery_pkg::*;
#(
  parameter int NUM_W   = 5,
  parameter int BALLS   = 4,
  parameter int SUM_W   = 10,
  parameter int MIN_HIT = 2,
  localparam int HIT_W  = $clog2(BALLS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_draw,
  input  logic             win_valid,
  input  logic [NUM_W-1:0] win_num,
  output logic             win_ready,
  input  logic             bet_valid,
  input  logic [NUM_W-1:0] bet_num,
  output logic             bet_ready,
  input  logic             rd_err,
  output logic             ticket_done,
  output logic [HIT_W-1:0] hit,
  output logic [SUM_W-1:0] sum,
  output logic [1:0]       err
);

  state_t state, state_next;

  logic [BALLS-1:0][NUM_W-1:0] win_regs;
  logic [HIT_W-1:0]            win_cnt;
  logic [HIT_W-1:0]            bet_cnt;
  logic [HIT_W-1:0]            run_hit;
  logic [2**NUM_W-1:0]         picked;     // numbers already entered on this ticket

  logic [BALLS-1:0] win_mask;
  logic             win_dup;
  logic             bet_hit;
  logic [HIT_W-1:0] final_hit;
  logic [SUM_W-1:0] next_sum;

  logic [1:0] err_next;
  logic       win_store;
  logic       win_clear;
  logic       bet_accept;
  logic       ticket_clear;
  logic       score;

  // Only slots below win_cnt hold live winning numbers; stale slots are ignored.
  always_comb begin
    win_mask = '0;
    for (int i = 0; i < BALLS; i++) win_mask[i] = (HIT_W'(i) < win_cnt);
  end

  bet_match #(.NUM_W(NUM_W), .BALLS(BALLS)) u_win_dup (
    .num   (win_num),
    .win   (win_regs),
    .valid (win_mask),
    .match (win_dup)
  );

  bet_match #(.NUM_W(NUM_W), .BALLS(BALLS)) u_bet_hit (
    .num   (bet_num),
    .win   (win_regs),
    .valid (win_mask),
    .match (bet_hit)
  );

  assign final_hit = run_hit + HIT_W'(bet_hit);
  assign next_sum  = SUM_W'(sat_add(int'(sum), prize(int'(final_hit), MIN_HIT), SUM_W));

  assign win_ready   = (state == LOAD_WIN);
  assign bet_ready   = (state == IDLE) || (state == BET);
  assign ticket_done = (state == SCORE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values, avoiding order races.
    if (reset) state <= LOAD_WIN;
    else       state <= state_next;
  end

  // Next-state decode plus the datapath strobes and the error code for this edge.
  always_comb begin
    state_next   = state;
    err_next     = ERR_NONE;
    win_store    = 1'b0;
    win_clear    = 1'b0;
    bet_accept   = 1'b0;
    ticket_clear = 1'b0;
    score        = 1'b0;
    if (new_draw) begin
      state_next   = LOAD_WIN;
      win_clear    = 1'b1;
      ticket_clear = 1'b1;
    end else begin
      case (state)
        LOAD_WIN: begin
          if (rd_err) begin
            win_clear = 1'b1;
            err_next  = ERR_RD;
          end else if (win_valid) begin
            if (win_num == '0)  err_next = ERR_ZERO;
            else if (win_dup)   err_next = ERR_DUP;
            else begin
              win_store = 1'b1;
              if (win_cnt == HIT_W'(BALLS - 1)) state_next = IDLE;
            end
          end
        end
        IDLE, BET: begin
          if (rd_err) begin
            ticket_clear = 1'b1;
            err_next     = ERR_RD;
            state_next   = IDLE;
          end else if (bet_valid) begin
            if (bet_num == '0)        err_next = ERR_ZERO;
            else if (picked[bet_num]) err_next = ERR_DUP;
            else begin
              bet_accept = 1'b1;
              if (bet_cnt == HIT_W'(BALLS - 1)) begin
                score      = 1'b1;
                state_next = SCORE;
              end else begin
                state_next = BET;
              end
            end
          end
        end
        SCORE: begin
          ticket_clear = 1'b1;
          state_next   = IDLE;
        end
        default: state_next = LOAD_WIN;
      endcase
    end
  end

  // Winning set, ticket progress, score outputs and the registered error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the winning slots and ticket bitmap are flop arrays, not RAM, so they reset like any register.
      win_regs <= '0;
      win_cnt  <= '0;
      bet_cnt  <= '0;
      run_hit  <= '0;
      picked   <= '0;
      hit      <= '0;
      sum      <= '0;
      err      <= ERR_NONE;
    end else begin
      err <= err_next;
      // Clearing the count is enough to empty the set: slots at or above win_cnt are masked out.
      if (win_clear) begin
        win_cnt <= '0;
      end else if (win_store) begin
        for (int i = 0; i < BALLS; i++) begin
          if (win_cnt == HIT_W'(i)) win_regs[i] <= win_num;
        end
        win_cnt <= win_cnt + 1'b1;
      end
      if (ticket_clear) begin
        bet_cnt <= '0;
        run_hit <= '0;
        picked  <= '0;
      end else if (bet_accept) begin
        picked[bet_num] <= 1'b1;
        bet_cnt         <= bet_cnt + 1'b1;
        run_hit         <= final_hit;
      end
      if (score) begin
        hit <= final_hit;
        sum <= next_sum;
      end
    end
  end

endmodule

// File: tb/tb_check_bet_multi.sv
// Self-checking bench: directed ticket scenarios plus randomized traffic, checked
// every cycle against a queue-based model of the draw, the ticket and the totals.
module tb_check_bet_multi;

  localparam int NUM_W = 5;
  localparam int BALLS = 4;
  localparam int HIT_W = $clog2(BALLS + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             new_draw = 1'b0;
  logic             win_valid = 1'b0;
  logic [NUM_W-1:0] win_num = '0;
  logic             bet_valid = 1'b0;
  logic [NUM_W-1:0] bet_num = '0;
  logic             rd_err = 1'b0;

  logic             win_ready, bet_ready, ticket_done;
  logic [HIT_W-1:0] hit;
  logic [9:0]       sum;
  logic [1:0]       err;

  logic             win_ready4, bet_ready4, ticket_done4;
  logic [HIT_W-1:0] hit4;
  logic [3:0]       sum4;
  logic [1:0]       err4;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  check_bet_multi #(.NUM_W(NUM_W), .BALLS(BALLS), .SUM_W(10), .MIN_HIT(2)) dut (
    .clk(clk), .reset(rst), .new_draw(new_draw),
    .win_valid(win_valid), .win_num(win_num), .win_ready(win_ready),
    .bet_valid(bet_valid), .bet_num(bet_num), .bet_ready(bet_ready),
    .rd_err(rd_err), .ticket_done(ticket_done), .hit(hit), .sum(sum), .err(err)
  );

  check_bet_multi #(.NUM_W(NUM_W), .BALLS(BALLS), .SUM_W(4), .MIN_HIT(2)) dut4 (
    .clk(clk), .reset(rst), .new_draw(new_draw),
    .win_valid(win_valid), .win_num(win_num), .win_ready(win_ready4),
    .bet_valid(bet_valid), .bet_num(bet_num), .bet_ready(bet_ready4),
    .rd_err(rd_err), .ticket_done(ticket_done4), .hit(hit4), .sum(sum4), .err(err4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 collecting the draw, 1 taking ticket numbers, 2 the scoring cycle
  int m_phase = 0;
  int win_q[$];
  int tkt_q[$];
  int m_hit = 0;
  int m_sum = 0;
  int m_sum4 = 0;
  int m_err = 0;

  function automatic bit in_q(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int score_ticket(input int w[$], input int t[$]);
    int h = 0;
    foreach (t[i]) if (in_q(w, t[i])) h++;
    return h;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_phase = 0; win_q.delete(); tkt_q.delete();
      m_hit = 0; m_sum = 0; m_sum4 = 0; m_err = 0;
    end else begin
      m_err = 0;
      if (new_draw) begin
        m_phase = 0; win_q.delete(); tkt_q.delete();
      end else if (m_phase == 0) begin
        if (rd_err) begin
          win_q.delete(); m_err = 3;
        end else if (win_valid) begin
          if (win_num == 0)                 m_err = 2;
          else if (in_q(win_q, int'(win_num))) m_err = 1;
          else begin
            win_q.push_back(int'(win_num));
            if (win_q.size() == BALLS) m_phase = 1;
          end
        end
      end else if (m_phase == 1) begin
        if (rd_err) begin
          tkt_q.delete(); m_err = 3;
        end else if (bet_valid) begin
          if (bet_num == 0)                    m_err = 2;
          else if (in_q(tkt_q, int'(bet_num))) m_err = 1;
          else begin
            tkt_q.push_back(int'(bet_num));
            if (tkt_q.size() == BALLS) begin
              int p;
              m_hit  = score_ticket(win_q, tkt_q);
              p      = (m_hit >= 2) ? m_hit * m_hit : 0;
              m_sum  = (m_sum + p > 1023) ? 1023 : m_sum + p;
              m_sum4 = (m_sum4 + p > 15) ? 15 : m_sum4 + p;
              m_phase = 2;
            end
          end
        end
      end else begin
        tkt_q.delete(); m_phase = 1;
      end
    end
  end

  // Per-cycle comparison of both instances against the model, away from the rising edge.
  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      check("cyc_win_ready",   win_ready,    m_phase == 0);
      check("cyc_bet_ready",   bet_ready,    m_phase == 1);
      check("cyc_ticket_done", ticket_done,  m_phase == 2);
      check("cyc_hit",         hit,          m_hit);
      check("cyc_sum",         sum,          m_sum);
      check("cyc_err",         err,          m_err);
      check("cyc4_win_ready",  win_ready4,   m_phase == 0);
      check("cyc4_bet_ready",  bet_ready4,   m_phase == 1);
      check("cyc4_done",       ticket_done4, m_phase == 2);
      check("cyc4_hit",        hit4,         m_hit);
      check("cyc4_sum",        sum4,         m_sum4);
      check("cyc4_err",        err4,         m_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_win(input int n);
    win_valid = 1'b1; win_num = NUM_W'(n);
    @(posedge clk); #2;
    win_valid = 1'b0;
  endtask

  task automatic load_draw(input int a, input int b, input int c, input int d);
    send_win(a); send_win(b); send_win(c); send_win(d);
  endtask

  task automatic send_bet(input int n);
    int k = 0;
    while (!bet_ready && k < 16) begin
      @(posedge clk); #2;
      k++;
    end
    if (!bet_ready) check("bet_ready_timeout", bet_ready, 1);
    bet_valid = 1'b1; bet_num = NUM_W'(n);
    @(posedge clk); #2;
    bet_valid = 1'b0;
  endtask

  task automatic ticket(input int a, input int b, input int c, input int d);
    send_bet(a); send_bet(b); send_bet(c); send_bet(d);
  endtask

  task automatic pulse_rd_err();
    rd_err = 1'b1;
    @(posedge clk); #2;
    rd_err = 1'b0;
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    #1;
    check("rst_win_ready", win_ready, 1);
    check("rst_bet_ready", bet_ready, 0);
    check("rst_done",      ticket_done, 0);
    check("rst_hit",       hit, 0);
    check("rst_sum",       sum, 0);
    check("rst_err",       err, 0);
    #12;
    @(negedge clk); #1;
    rst = 1'b0;
    cmp_en = 1'b1;

    load_draw(4, 21, 22, 30);
    check("load_win_ready", win_ready, 0);
    check("load_bet_ready", bet_ready, 1);

    ticket(1, 3, 22, 26);
    check("t1_done", ticket_done, 1);
    check("t1_hit",  hit, 1);
    check("t1_sum",  sum, 0);
    ticket(4, 21, 23, 30);
    check("t2_hit", hit, 3);
    check("t2_sum", sum, 9);
    ticket(21, 22, 23, 24);
    check("t3_hit", hit, 2);
    check("t3_sum", sum, 13);
    ticket(4, 28, 29, 31);
    check("t4_hit", hit, 1);
    check("t4_sum", sum, 13);

    // repeated number on one ticket
    send_bet(4);
    send_bet(4);
    check("dup_err", err, 1);
    send_bet(21);
    send_bet(22);
    check("dup_not_done", ticket_done, 0);
    send_bet(30);
    check("dup_done", ticket_done, 1);
    check("dup_hit",  hit, 4);
    check("dup_sum",  sum, 29);
    check("dup_sum4", sum4, 15);

    // zero bet, then read abort after two bets
    send_bet(0);
    check("zero_err", err, 2);
    send_bet(4);
    send_bet(21);
    pulse_rd_err();
    check("rd_err_code", err, 3);
    check("rd_done",     ticket_done, 0);
    check("rd_sum",      sum, 29);
    check("rd_hit",      hit, 4);
    ticket(4, 21, 1, 2);
    check("after_rd_hit", hit, 2);
    check("after_rd_sum", sum, 33);

    // new_draw mid-ticket beats a same-cycle bet handshake
    send_bet(4);
    send_bet(5);
    new_draw = 1'b1; bet_valid = 1'b1; bet_num = 5'd21;
    @(posedge clk); #2;
    new_draw = 1'b0; bet_valid = 1'b0;
    check("nd_win_ready", win_ready, 1);
    check("nd_bet_ready", bet_ready, 0);
    check("nd_sum",       sum, 33);
    check("nd_hit",       hit, 2);
    load_draw(4, 21, 22, 30);
    ticket(4, 21, 22, 30);
    check("nd_next_hit", hit, 4);
    check("nd_next_sum", sum, 49);

    // asynchronous reset in the middle of a ticket
    send_bet(1);
    send_bet(2);
    rst = 1'b1;
    #1;
    check("arst_win_ready", win_ready, 1);
    check("arst_bet_ready", bet_ready, 0);
    check("arst_hit",       hit, 0);
    check("arst_sum",       sum, 0);
    check("arst_sum4",      sum4, 0);
    check("arst_err",       err, 0);
    @(negedge clk); #1;
    rst = 1'b0;

    // saturation of both totals
    load_draw(4, 21, 22, 30);
    ticket(4, 21, 22, 30);
    check("sat4_first", sum4, 15);
    check("sat_first",  sum, 16);
    for (int i = 0; i < 3; i++) ticket(30, 22, 21, 4);
    check("sat4_held", sum4, 15);
    check("sat_64",    sum, 64);
    for (int i = 0; i < 60; i++) ticket(4, 22, 30, 21);
    check("sat_max", sum, 1023);

    // randomized traffic, including draw reloads and errors
    @(posedge clk); #2;
    new_draw = 1'b1;
    @(posedge clk); #2;
    for (int c = 0; c < 4000; c++) begin
      new_draw  = ($urandom_range(0, 199) == 0);
      rd_err    = ($urandom_range(0, 39) == 0);
      win_valid = ($urandom_range(0, 1) == 1);
      win_num   = NUM_W'($urandom_range(0, 12));
      bet_valid = ($urandom_range(0, 3) != 0);
      bet_num   = NUM_W'($urandom_range(0, 12));
      @(posedge clk); #2;
    end
    new_draw = 1'b0; rd_err = 1'b0; win_valid = 1'b0; bet_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
